// File: rtl/ghist_checkpoint_queue.sv
// ghist_checkpoint_queue
// Circular buffer of branch-history checkpoints, one entry per predicted
// fetch block. Entries are enqueued in program order, retired in order by
// commit, and a backend squash returns the checkpoint of the mispredicted
// block while truncating every younger entry.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   enq_valid/enq_ready - enqueue handshake; enq_tag is the slot written
//   enq_ghist_idx       - history index at block start
//   enq_fold            - folded TAGE history at block start
//   commit_valid        - retire the head entry (ignored when empty)
//   squash_valid/tag    - redirect at the entry with the given tag
//   restore_valid       - one-cycle pulse; restore_* data holds until the
//                         next live squash
//   squash_err          - one-cycle pulse when the squash tag was not live
//   count/empty/full    - occupancy derived from the registered pointers
module ghist_checkpoint_queue #(
  parameter int DEPTH       = 32,
  parameter int GHIST_WIDTH = 8,
  parameter int FOLD_WIDTH  = 96,
  parameter int TAG_W       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [GHIST_WIDTH-1:0] enq_ghist_idx,
  input  logic [FOLD_WIDTH-1:0]  enq_fold,
  output logic [TAG_W-1:0]       enq_tag,
  input  logic                   commit_valid,
  input  logic                   squash_valid,
  input  logic [TAG_W-1:0]       squash_tag,
  output logic                   restore_valid,
  output logic [GHIST_WIDTH-1:0] restore_ghist_idx,
  output logic [FOLD_WIDTH-1:0]  restore_fold,
  output logic                   squash_err,
  output logic [TAG_W:0]         count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = TAG_W + 1;
  localparam int EW = GHIST_WIDTH + FOLD_WIDTH;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    tail_ptr;
  logic [EW-1:0]    mem [DEPTH];

  logic [TAG_W-1:0] offset;
  logic             live;
  logic             squash_fire;
  logic             enq_fire;
  logic             commit_fire;
  logic [PW-1:0]    squash_tail;

  assign count     = tail_ptr - head_ptr;
  assign empty     = (count == '0);
  assign full      = (count == PW'(DEPTH));
  assign enq_ready = ~full & ~squash_valid;
  assign enq_tag   = tail_ptr[TAG_W-1:0];

  // Distance from the (pre-commit) head to the squashed slot, modulo DEPTH.
  // The tag is live only if that distance lands inside the occupied region.
  assign offset      = squash_tag - head_ptr[TAG_W-1:0];
  assign live        = ({1'b0, offset} < count);
  assign squash_fire = squash_valid & live;
  assign enq_fire    = enq_valid & enq_ready;
  assign commit_fire = commit_valid & ~empty;

  // The squashed block survives; the tail lands just past it.
  assign squash_tail = head_ptr + {1'b0, offset} + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (commit_fire) begin
        head_ptr <= head_ptr + PW'(1);
      end
      // enq_ready is already low during a squash, so these never collide.
      if (squash_fire) begin
        tail_ptr <= squash_tail;
      end else if (enq_fire) begin
        tail_ptr <= tail_ptr + PW'(1);
      end
    end
  end

  // Storage is not reset; only live slots are ever read back.
  always_ff @(posedge clk) begin
    if (enq_fire && !rst) begin
      mem[tail_ptr[TAG_W-1:0]] <= {enq_ghist_idx, enq_fold};
    end
  end

  // Restore data is registered and held until the next live squash.
  always_ff @(posedge clk) begin
    if (rst) begin
      restore_valid     <= 1'b0;
      squash_err        <= 1'b0;
      restore_ghist_idx <= '0;
      restore_fold      <= '0;
    end else begin
      restore_valid <= squash_fire;
      squash_err    <= squash_valid & ~live;
      if (squash_fire) begin
        {restore_ghist_idx, restore_fold} <= mem[squash_tag];
      end
    end
  end

endmodule
